// File: rtl/otp_resp_emu.sv
// otp_resp_emu: cycle-accurate stand-in for the OTP code-memory macro, one byte lane.
// Build option: define OTP_OVERPGM_CHK_EN to flag re-programming of an already-set bit.
module otp_resp_emu #(
   parameter int AW     = 13,
   parameter int DEPTH  = 8192,
   parameter int RD_LAT = 2,
   parameter int PW_MIN = 20,
   parameter int PW_MAX = 200
) (
   input  logic        i_clk,
   input  logic        i_rstz,
   input  logic        pmem_csb,
   input  logic        pmem_re,
   input  logic        pmem_pgm,
   input  logic        pmem_clk,
   input  logic [15:0] pmem_a,
   input  logic [1:0]  pmem_twlb,
   input  logic [1:0]  pmem_sap,
   input  logic        vddp_ok,
   output logic [7:0]  pmem_q,
   output logic        busy,
   output logic        pgm_err,
   output logic [15:0] pgm_cnt
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
   localparam logic [7:0] PW_MIN_W = 8'(PW_MIN);
   localparam logic [7:0] PW_MAX_W = 8'(PW_MAX);

   typedef enum logic [1:0] {IDLE, READ, PGM} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_clkD;
   logic [AW-1:0]   r_raddr;
   logic [1:0]      r_rsap;
   logic [2:0]      r_latCnt;
   logic [AW-1:0]   r_paddr;
   logic [2:0]      r_pbit;
   logic [1:0]      r_ptwlb;
   logic [7:0]      r_width;
   logic            r_pendErr;
   logic [7:0]      r_q;
   logic            r_err;
   logic [15:0]     r_cnt;

   // Emulated non-volatile array: never touched by reset.
   logic [7:0]      r_mem  [DEPTH];
   logic            r_weak [DEPTH];

   logic            w_rise;
   logic            w_fall;
   logic [IW-1:0]   w_rIdx;
   logic [IW-1:0]   w_pIdx;
   logic            w_rInRange;
   logic            w_pInRange;
   logic [7:0]      w_rByte;
   logic [7:0]      w_pByte;
   logic [7:0]      w_bitMask;
   logic            w_bitSet;
   logic [7:0]      w_dout;
   logic            w_loadRead;
   logic            w_loadPgm;
   logic            w_qLoad;
   logic            w_setErr;
   logic            w_memWe;
   logic            w_weakSet;
   logic            w_weakClr;
   logic            w_cntInc;

   assign w_rise     = pmem_clk & ~r_clkD;
   assign w_fall     = ~pmem_clk & r_clkD;
   assign w_rIdx     = r_raddr[IW-1:0];
   assign w_pIdx     = r_paddr[IW-1:0];
   assign w_rInRange = (32'(r_raddr) < 32'(DEPTH));
   assign w_pInRange = (32'(r_paddr) < 32'(DEPTH));
   assign w_rByte    = r_mem[w_rIdx];
   assign w_pByte    = r_mem[w_pIdx];
   assign w_bitMask  = 8'h01 << r_pbit;
   assign w_bitSet   = |(w_pByte & w_bitMask);

   // Margin read hides every bit of a byte that holds a weakly programmed cell.
   always_comb begin
      w_dout = 8'h00;
      if (w_rInRange) begin
         if (r_rsap == 2'b00) w_dout = w_rByte;
         else                 w_dout = w_rByte & {8{~r_weak[w_rIdx]}};
      end
   end

   always_ff @(posedge i_clk or negedge i_rstz) begin
      if (!i_rstz) r_state <= IDLE;
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_loadRead  = 1'b0;
      w_loadPgm   = 1'b0;
      w_qLoad     = 1'b0;
      w_setErr    = 1'b0;
      w_memWe     = 1'b0;
      w_weakSet   = 1'b0;
      w_weakClr   = 1'b0;
      w_cntInc    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise && !pmem_csb) begin
               if (pmem_re && pmem_pgm) begin
                  w_setErr = 1'b1;
               end else if (pmem_re) begin
                  w_loadRead  = 1'b1;
                  w_nextState = READ;
               end else if (pmem_pgm) begin
                  w_loadPgm   = 1'b1;
                  w_nextState = PGM;
               end
            end
         end
         READ: begin
            if (pmem_csb) begin
               w_nextState = IDLE;
            end else begin
               if (w_rise) w_setErr = 1'b1;
               if (r_latCnt == 3'd1) begin
                  w_qLoad     = 1'b1;
                  w_nextState = IDLE;
               end
            end
         end
         PGM: begin
            if (w_fall) begin
               w_nextState = IDLE;
               if ((r_ptwlb != 2'b11) || !vddp_ok || pmem_csb || !w_pInRange || r_pendErr) begin
                  w_setErr = 1'b1;
               end else begin
                  w_memWe  = 1'b1;
                  w_cntInc = 1'b1;
`ifdef OTP_OVERPGM_CHK_EN
                  if (w_bitSet)                w_setErr  = 1'b1;
                  else if (r_width > PW_MAX_W) w_setErr  = 1'b1;
                  else if (r_width < PW_MIN_W) w_weakSet = 1'b1;
`else
                  if (r_width > PW_MAX_W)      w_setErr  = 1'b1;
                  else if (r_width < PW_MIN_W) w_weakSet = 1'b1;
                  else if (w_bitSet)           w_weakClr = 1'b1;
`endif
               end
            end else if (!pmem_pgm) begin
               w_nextState = IDLE;
               w_setErr    = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstz) begin
      if (!i_rstz) begin
         r_clkD    <= 1'b0;
         r_raddr   <= '0;
         r_rsap    <= 2'b00;
         r_latCnt  <= 3'd0;
         r_paddr   <= '0;
         r_pbit    <= 3'd0;
         r_ptwlb   <= 2'b00;
         r_width   <= 8'd0;
         r_pendErr <= 1'b0;
         r_q       <= 8'h00;
         r_err     <= 1'b0;
         r_cnt     <= 16'd0;
      end else begin
         r_clkD <= pmem_clk;
         if (w_loadRead) begin
            r_raddr  <= pmem_a[AW-1:0];
            r_rsap   <= pmem_sap;
            r_latCnt <= LAT_INIT;
         end else if (r_state == READ) begin
            r_latCnt <= r_latCnt - 3'd1;
         end
         if (w_loadPgm) begin
            r_paddr   <= pmem_a[AW-1:0];
            r_pbit    <= pmem_a[15:13];
            r_ptwlb   <= pmem_twlb;
            r_width   <= 8'd0;
            r_pendErr <= 1'b0;
         end else if (r_state == PGM) begin
            if (pmem_clk && (r_width != 8'hFF)) r_width <= r_width + 8'd1;
            if (!vddp_ok) r_pendErr <= 1'b1;
         end
         if (w_qLoad) r_q <= w_dout;
         if (w_setErr) r_err <= 1'b1;
         if (w_cntInc && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_memWe) r_mem[w_pIdx] <= w_pByte | w_bitMask;
      if (w_weakSet)      r_weak[w_pIdx] <= 1'b1;
      else if (w_weakClr) r_weak[w_pIdx] <= 1'b0;
   end

   assign pmem_q  = r_q;
   assign busy    = (r_state != IDLE);
   assign pgm_err = r_err;
   assign pgm_cnt = r_cnt;
endmodule
